// File: rtl/line_buf_ctrl_if.sv
// Bundle between the line-buffer controller and its neighbours: pixel input
// stream, write/read strobes to four line buffers, their 3-pixel taps, the
// 3x3 window output with its handshake, and the per-line interrupt.
// slave = controller side, master = environment (source, buffers, sink).
interface line_buf_ctrl_if #(
  parameter int PIXEL_SIZE = 8
);
  logic [PIXEL_SIZE-1:0]   i_pixel;
  logic                    i_pixel_valid;
  logic                    o_pixel_ready;
  logic [PIXEL_SIZE-1:0]   o_lb_data;
  logic [3:0]              o_lb_wr;
  logic [3:0]              o_lb_rd;
  logic [3*PIXEL_SIZE-1:0] i_lb0_data;
  logic [3*PIXEL_SIZE-1:0] i_lb1_data;
  logic [3*PIXEL_SIZE-1:0] i_lb2_data;
  logic [3*PIXEL_SIZE-1:0] i_lb3_data;
  logic [9*PIXEL_SIZE-1:0] o_window;
  logic                    o_window_valid;
  logic                    i_window_ready;
  logic                    o_intr;

  modport slave (
    input  i_pixel, i_pixel_valid, i_lb0_data, i_lb1_data, i_lb2_data,
           i_lb3_data, i_window_ready,
    output o_pixel_ready, o_lb_data, o_lb_wr, o_lb_rd, o_window,
           o_window_valid, o_intr
  );

  modport master (
    output i_pixel, i_pixel_valid, i_lb0_data, i_lb1_data, i_lb2_data,
           i_lb3_data, i_window_ready,
    input  o_pixel_ready, o_lb_data, o_lb_wr, o_lb_rd, o_window,
           o_window_valid, o_intr
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller: writes a pixel stream round-robin into four line
// buffers and reads three of them together as a 3x3 window stream.
// Ports: clk, reset (async, active-high), bus (line_buf_ctrl_if.slave):
//   pixel in (valid/ready), lb write/read strobes + taps, window out
//   (valid/ready), o_intr per consumed line.
// Latency: window/strobes are combinational from taps and state; window
//   valid follows the edge at which three lines are buffered.
// Backpressure: o_pixel_ready drops when all four lines are full; the window
//   holds while o_window_valid && !i_window_ready.
// Optional: define LINE_BUF_CTRL_INTR_EN for the registered o_intr pulse.
module line_buf_ctrl #(
  parameter int PIXEL_SIZE  = 8,
  parameter int IMAGE_WIDTH = 512
) (
  input  logic             clk,
  input  logic             reset,
  line_buf_ctrl_if.slave   bus
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int OW = $clog2(4*IMAGE_WIDTH + 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(4*IMAGE_WIDTH);
  localparam logic [OW-1:0] OCC_START = OW'(3*IMAGE_WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(IMAGE_WIDTH-1);

  typedef enum logic {IDLE, READ} state_t;

  state_t                  state;
  logic [CW-1:0]           wr_cnt;
  logic [CW-1:0]           rd_cnt;
  logic [1:0]              wr_sel;
  logic [1:0]              rd_sel;
  logic [1:0]              rd_sel1;
  logic [1:0]              rd_sel2;
  logic [OW-1:0]           occ;
  logic [OW-1:0]           occ_nxt;
  logic                    ready;
  logic                    accept;
  logic                    rd;
  logic                    line_done;
  logic [3:0]              lb_wr;
  logic [3:0]              lb_rd;
  logic [3*PIXEL_SIZE-1:0] tap [4];

  // Ready looks only at the registered fill level, so a read in the same
  // cycle frees a slot only from the next edge on.
  assign ready     = (occ != OCC_FULL);
  assign accept    = bus.i_pixel_valid && ready;
  assign rd        = (state == READ) && bus.i_window_ready;
  assign line_done = rd && (rd_cnt == CNT_LAST);
  assign rd_sel1   = rd_sel + 2'd1;
  assign rd_sel2   = rd_sel + 2'd2;

  assign tap[0] = bus.i_lb0_data;
  assign tap[1] = bus.i_lb1_data;
  assign tap[2] = bus.i_lb2_data;
  assign tap[3] = bus.i_lb3_data;

  always_comb begin
    case ({accept, rd})
      2'b10:   occ_nxt = occ + OW'(1);
      2'b01:   occ_nxt = occ - OW'(1);
      default: occ_nxt = occ;
    endcase
  end

  always_comb begin
    lb_wr = '0;
    if (accept) lb_wr[wr_sel] = 1'b1;
  end

  always_comb begin
    lb_rd = '0;
    if (rd) begin
      lb_rd[rd_sel]  = 1'b1;
      lb_rd[rd_sel1] = 1'b1;
      lb_rd[rd_sel2] = 1'b1;
    end
  end

  assign bus.o_pixel_ready  = ready;
  assign bus.o_lb_data      = bus.i_pixel;
  assign bus.o_lb_wr        = lb_wr;
  assign bus.o_lb_rd        = lb_rd;
  assign bus.o_window_valid = (state == READ);
  // Oldest line (rd_sel) lands in the MSBs.
  assign bus.o_window       = {tap[rd_sel], tap[rd_sel1], tap[rd_sel2]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      wr_sel <= '0;
      occ    <= '0;
    end else begin
      occ <= occ_nxt;
      if (accept) begin
        if (wr_cnt == CNT_LAST) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
    end
  end

  // Read FSM. In IDLE no read happens, so occ_nxt already includes the write
  // of this cycle and the window appears right after the third line lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rd_cnt <= '0;
      rd_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (occ_nxt >= OCC_START) state <= READ;
        end
        READ: begin
          if (line_done) begin
            rd_cnt <= '0;
            rd_sel <= rd_sel + 2'd1;
            state  <= IDLE;
          end else if (rd) begin
            rd_cnt <= rd_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_BUF_CTRL_INTR_EN
  logic intr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) intr_q <= 1'b0;
    else       intr_q <= line_done;
  end
  assign bus.o_intr = intr_q;
`else
  assign bus.o_intr = 1'b0;
`endif
endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl with IMAGE_WIDTH=4: a table of hand-derived vectors
// for the 12-pixel stream, hand sequences for full/drop/reset corners, and
// random traffic checked against a pixel/window counting model.
module tb_line_buf_ctrl;
  localparam int PS = 8;
  localparam int W  = 4;
`ifdef LINE_BUF_CTRL_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  line_buf_ctrl_if #(.PIXEL_SIZE(PS)) bus ();

  line_buf_ctrl #(.PIXEL_SIZE(PS), .IMAGE_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3*PS-1:0] tap [4];
  assign bus.i_lb0_data = tap[0];
  assign bus.i_lb1_data = tap[1];
  assign bus.i_lb2_data = tap[2];
  assign bus.i_lb3_data = tap[3];

  int total;
  int bad;

  // Model: pixels written and windows read since reset; everything else is
  // derived from these two numbers.
  int       written;
  int       reads;
  bit       in_read;
  bit       intr_pend;
  bit       cur_v;
  bit       cur_r;
  logic [PS-1:0] cur_pix;
  logic [9*PS-1:0] prev_win;
  bit       prev_stall;
  int       dut_reads;

  typedef struct {
    bit       v;
    bit       r;
    bit       e_ready;
    bit       e_valid;
    logic [3:0] e_wr;
    logic [3:0] e_rd;
    bit       e_intr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [9*PS-1:0] act,
                     input logic [9*PS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    written = 0; reads = 0; in_read = 0; intr_pend = 0; prev_stall = 0;
  endtask

  // Called one time unit after a rising edge: apply inputs, settle to the
  // falling edge.
  task automatic drive(input bit v, input bit r);
    int unsigned p;
    p = $urandom;
    cur_v = v; cur_r = r; cur_pix = p[PS-1:0];
    bus.i_pixel_valid  = v;
    bus.i_window_ready = r;
    bus.i_pixel        = cur_pix;
    #4;
  endtask

  // Compare against the model (optional), cross the rising edge, update.
  task automatic advance(input bit do_chk);
    int occ, wsel, rsel;
    bit e_ready, acc, rdv;
    logic [3:0] e_wr, e_rd;
    logic [9*PS-1:0] e_win;
    occ  = written - reads;
    wsel = (written / W) % 4;
    rsel = (reads / W) % 4;
    e_ready = (occ != 4*W);
    acc  = cur_v && e_ready;
    rdv  = in_read && cur_r;
    e_wr = acc ? 4'(1 << wsel) : 4'b0;
    e_rd = rdv ? (4'(1 << rsel) | 4'(1 << ((rsel+1)%4)) | 4'(1 << ((rsel+2)%4))) : 4'b0;
    e_win = {tap[rsel], tap[(rsel+1)%4], tap[(rsel+2)%4]};
    if (do_chk) begin
      chk("pixel_ready", 72'(bus.o_pixel_ready), 72'(e_ready));
      chk("window_valid", 72'(bus.o_window_valid), 72'(in_read));
      chk("lb_wr", 72'(bus.o_lb_wr), 72'(e_wr));
      chk("lb_rd", 72'(bus.o_lb_rd), 72'(e_rd));
      chk("window", bus.o_window, e_win);
      chk("lb_data", 72'(bus.o_lb_data), 72'(cur_pix));
      chk("intr", 72'(bus.o_intr), 72'(INTR_EN && intr_pend));
      if (prev_stall && in_read) chk("stall_hold", bus.o_window, prev_win);
    end
    if (bus.o_window_valid && cur_r) dut_reads++;
    prev_stall = in_read && !cur_r;
    prev_win   = bus.o_window;
    @(posedge clk);
    written += int'(acc);
    reads   += int'(rdv);
    intr_pend = rdv && (reads % W == 0);
    if (in_read) begin
      if (rdv && (reads % W == 0)) in_read = 0;
    end else if (written - reads >= 3*W) begin
      in_read = 1;
    end
    // Emulated line buffers: only the buffers that advanced present new taps.
    for (int k = 0; k < 4; k++) if (e_rd[k]) tap[k] = 24'($urandom);
    #1;
  endtask

  // Called from the settle phase of a cycle; returns one unit after an edge.
  task automatic reset_dut();
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 72'(bus.o_window_valid), 72'(0));
    chk("rst_async_ready", 72'(bus.o_pixel_ready), 72'(1));
    chk("rst_async_rd", 72'(bus.o_lb_rd), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    total = 0; bad = 0; dut_reads = 0;
    reset = 1'b1;
    bus.i_pixel = '0; bus.i_pixel_valid = 1'b0; bus.i_window_ready = 1'b0;
    for (int k = 0; k < 4; k++) tap[k] = 24'($urandom);
    model_reset();

    // Table for 12 pixels streamed with the sink always ready.
    for (int i = 0; i < 18; i++) begin
      vecs[i].v = (i < 12); vecs[i].r = 1'b1; vecs[i].e_ready = 1'b1;
      vecs[i].e_valid = (i >= 12 && i < 16);
      vecs[i].e_wr = (i < 12) ? 4'(1 << (i / 4)) : 4'b0;
      vecs[i].e_rd = (i >= 12 && i < 16) ? 4'b0111 : 4'b0000;
      vecs[i].e_intr = (i == 16) ? INTR_EN : 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0);
    chk("reset_ready", 72'(bus.o_pixel_ready), 72'(1));
    chk("reset_valid", 72'(bus.o_window_valid), 72'(0));
    chk("reset_wr", 72'(bus.o_lb_wr), 72'(0));
    chk("reset_rd", 72'(bus.o_lb_rd), 72'(0));
    chk("reset_intr", 72'(bus.o_intr), 72'(0));
    advance(1);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v, vecs[i].r);
      chk($sformatf("tab%0d_ready", i), 72'(bus.o_pixel_ready), 72'(vecs[i].e_ready));
      chk($sformatf("tab%0d_valid", i), 72'(bus.o_window_valid), 72'(vecs[i].e_valid));
      chk($sformatf("tab%0d_wr", i), 72'(bus.o_lb_wr), 72'(vecs[i].e_wr));
      chk($sformatf("tab%0d_rd", i), 72'(bus.o_lb_rd), 72'(vecs[i].e_rd));
      chk($sformatf("tab%0d_intr", i), 72'(bus.o_intr), 72'(vecs[i].e_intr));
      advance(0);
    end

    // Next row must start at buffer 1.
    for (int i = 0; i < 4; i++) begin drive(1, 1); advance(1); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1);
      chk("rdsel1_window", bus.o_window, {tap[1], tap[2], tap[3]});
      chk("rdsel1_rd", 72'(bus.o_lb_rd), 72'(4'b1110));
      advance(1);
    end

    // Fill all four lines with the sink stalled; the 17th pixel is dropped.
    drive(0, 0);
    reset_dut();
    for (int i = 0; i < 16; i++) begin drive(1, 0); advance(1); end
    drive(1, 0);
    chk("full_ready", 72'(bus.o_pixel_ready), 72'(0));
    chk("drop_wr", 72'(bus.o_lb_wr), 72'(0));
    chk("full_valid", 72'(bus.o_window_valid), 72'(1));
    advance(1);
    // Read and offered write together while full: ready rises only next edge.
    drive(1, 1);
    chk("fullrd_ready", 72'(bus.o_pixel_ready), 72'(0));
    chk("fullrd_wr", 72'(bus.o_lb_wr), 72'(0));
    chk("fullrd_rd", 72'(bus.o_lb_rd), 72'(4'b0111));
    advance(1);
    drive(0, 0);
    chk("after_rd_ready", 72'(bus.o_pixel_ready), 72'(1));
    chk("mid_read_valid", 72'(bus.o_window_valid), 72'(1));
    // Reset in the middle of a READ line.
    reset_dut();
    drive(0, 1);
    chk("post_rst_valid", 72'(bus.o_window_valid), 72'(0));
    chk("post_rst_ready", 72'(bus.o_pixel_ready), 72'(1));
    advance(1);

    // 40-pixel continuous stream, sink toggling, then always ready.
    drive(0, 0);
    reset_dut();
    dut_reads = 0;
    for (int c = 0; c < 300; c++) begin
      drive(written < 40, (written >= 40) ? 1'b1 : c[0]);
      advance(1);
    end
    chk("stream40_written", 72'(written), 72'(40));
    chk("stream40_windows", 72'(dut_reads), 72'(reads));
    chk("stream40_rdsel", 72'((reads / W) % 4), 72'((dut_reads / W) % 4));

    // Random traffic against the model.
    drive(0, 0);
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      advance(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
